regfile_reader: RTL and testbench

//  Register-bank read side of the processor: 32x32 bank with two read ports (rs, rt)
//  and one write-back port. Registered read data with write-back bypass, plus a

---
 rtl/regfile_reader_pkg.sv | 20 ++
 rtl/regfile_scoreboard.sv | 49 ++++
 rtl/regfile_reader.sv | 77 +++++++
 tb/tb_regfile_reader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_reader_pkg.sv
// Shared register-bank constants and the destination-selector encoding.
package regfile_reader_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREG   = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] RA_ADDR  = 5'b11111;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'b00000;

    typedef enum logic [1:0] {
        REGDST_RT = 2'b00,
        REGDST_RD = 2'b01,
        REGDST_RA = 2'b10
    } regdst_e;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: busy flops, write-back release, hazard detect.
module regfile_scoreboard
    import regfile_reader_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            rd_valid,
    input  reg_addr_t       rd_addr_a,
    input  reg_addr_t       rd_addr_b,
    input  logic            claim_valid,
    input  reg_addr_t       claim_addr,
    input  logic            wb_en,
    input  reg_addr_t       wb_addr,
    output logic            rd_ready,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] busy_eff;
    logic            accept;

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        for (int n = 1; n < NREG; n++) begin
            clr_vec[n] = wb_en && (wb_addr == reg_addr_t'(n));
            set_vec[n] = claim_valid && (claim_addr == reg_addr_t'(n));
        end
    end

    // A register released this cycle no longer blocks readers or claimers.
    assign busy_eff = busy_vec & ~clr_vec;

    assign rd_ready = !(busy_eff[rd_addr_a] ||
                        busy_eff[rd_addr_b] ||
                        (claim_valid && busy_eff[claim_addr]));

    assign accept = rd_valid && rd_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_eff | (accept ? set_vec : '0);
        end
    end

endmodule

// File: rtl/regfile_reader.sv
// Register bank with registered two-port read, write-back bypass and
// a scoreboard that stalls reads of registers with a pending write.
module regfile_reader
    import regfile_reader_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            rd_valid,
    output logic            rd_ready,
    input  reg_addr_t       rd_addr_a,
    input  reg_addr_t       rd_addr_b,
    input  logic            claim_valid,
    input  reg_addr_t       claim_addr,
    output reg_data_t       rd_data_a,
    output reg_data_t       rd_data_b,
    output logic            rd_data_vld,
    input  logic            wb_en,
    input  reg_addr_t       wb_addr,
    input  reg_data_t       wb_data,
    output logic [NREG-1:0] busy_vec
);

    reg_data_t bank [NREG];
    reg_data_t byp_a;
    reg_data_t byp_b;
    logic      wb_live;
    logic      accept;

    regfile_scoreboard u_sb (
        .clock       (clock),
        .reset       (reset),
        .rd_valid    (rd_valid),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .rd_ready    (rd_ready),
        .busy_vec    (busy_vec)
    );

    assign wb_live = wb_en && (wb_addr != REG_ZERO);
    assign accept  = rd_valid && rd_ready;

    always_comb begin
        byp_a = bank[rd_addr_a];
        byp_b = bank[rd_addr_b];
        if (wb_live && wb_addr == rd_addr_a) byp_a = wb_data;
        if (wb_live && wb_addr == rd_addr_b) byp_b = wb_data;
        if (rd_addr_a == REG_ZERO) byp_a = '0;
        if (rd_addr_b == REG_ZERO) byp_b = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < NREG; n++) bank[n] <= '0;
        end else if (wb_live) begin
            bank[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_a   <= '0;
            rd_data_b   <= '0;
            rd_data_vld <= 1'b0;
        end else begin
            rd_data_vld <= accept;
            if (accept) begin
                rd_data_a <= byp_a;
                rd_data_b <= byp_b;
            end
        end
    end

endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader: bypass, scoreboard stalls, r0, reset.
module tb_regfile_reader;
    import regfile_reader_pkg::*;

    logic            clock;
    logic            reset;
    logic            rd_valid;
    logic            rd_ready;
    reg_addr_t       rd_addr_a;
    reg_addr_t       rd_addr_b;
    logic            claim_valid;
    reg_addr_t       claim_addr;
    reg_data_t       rd_data_a;
    reg_data_t       rd_data_b;
    logic            rd_data_vld;
    logic            wb_en;
    reg_addr_t       wb_addr;
    reg_data_t       wb_data;
    logic [NREG-1:0] busy_vec;

    int checks = 0;
    int errors = 0;

    regfile_reader dut (
        .clock       (clock),
        .reset       (reset),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .rd_data_a   (rd_data_a),
        .rd_data_b   (rd_data_b),
        .rd_data_vld (rd_data_vld),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .busy_vec    (busy_vec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h exp %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic v, input reg_addr_t a, input reg_addr_t b,
                      input logic cv, input reg_addr_t ca);
        rd_valid    = v;
        rd_addr_a   = a;
        rd_addr_b   = b;
        claim_valid = cv;
        claim_addr  = ca;
    endtask

    task automatic wb(input logic e, input reg_addr_t a, input reg_data_t d);
        wb_en   = e;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        reset = 1'b0;
        rd(1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_vld", {31'b0, rd_data_vld}, 32'h0);
        chk("rst_da", rd_data_a, 32'h0);
        chk("rst_ready", {31'b0, rd_ready}, 32'h1);

        // write r5 to a non-busy register, then read it back
        wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        chk("wb_nobusy", busy_vec, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        rd(1'b1, 5'd5, 5'd0, 1'b0, 5'd0);
        tick();
        chk("t2_da", rd_data_a, 32'hDEAD_BEEF);
        chk("t2_db", rd_data_b, 32'h0);
        chk("t2_vld", {31'b0, rd_data_vld}, 32'h1);

        // idle cycles hold the data and drop valid
        rd(1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        tick();
        chk("t6_vld1", {31'b0, rd_data_vld}, 32'h0);
        tick();
        chk("t6_vld2", {31'b0, rd_data_vld}, 32'h0);
        chk("t6_da", rd_data_a, 32'hDEAD_BEEF);
        chk("t6_db", rd_data_b, 32'h0);

        // claim r31, then stalled read until write-back bypasses
        rd(1'b1, 5'd5, 5'd0, 1'b1, RA_ADDR);
        tick();
        chk("t3_busy", busy_vec, 32'h8000_0000);
        rd(1'b1, 5'd31, 5'd0, 1'b0, 5'd0);
        #1;
        chk("t3_stall", {31'b0, rd_ready}, 32'h0);
        tick();
        chk("t3_stall_vld", {31'b0, rd_data_vld}, 32'h0);
        chk("t3_stall_busy", busy_vec, 32'h8000_0000);
        wb(1'b1, RA_ADDR, 32'h40);
        #1;
        chk("t3_ready", {31'b0, rd_ready}, 32'h1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        rd(1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        chk("t3_byp", rd_data_a, 32'h40);
        chk("t3_vld", {31'b0, rd_data_vld}, 32'h1);
        chk("t3_rel", busy_vec, 32'h0);

        // WAW on r8: blocked until same-cycle write-back, set wins
        rd(1'b1, 5'd0, 5'd0, 1'b1, 5'd8);
        tick();
        chk("t4_busy", busy_vec, 32'h0000_0100);
        #1;
        chk("t4_waw", {31'b0, rd_ready}, 32'h0);
        tick();
        chk("t4_waw_vld", {31'b0, rd_data_vld}, 32'h0);
        wb(1'b1, 5'd8, 32'h88);
        #1;
        chk("t4_ready", {31'b0, rd_ready}, 32'h1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("t4_setwins", busy_vec, 32'h0000_0100);
        chk("t4_vld", {31'b0, rd_data_vld}, 32'h1);

        // r0 writes ignored and never claimed
        rd(1'b1, 5'd0, 5'd0, 1'b1, REG_ZERO);
        wb(1'b1, REG_ZERO, 32'hFFFF_FFFF);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("t5_busy", busy_vec, 32'h0000_0100);
        rd(1'b1, 5'd0, 5'd8, 1'b0, 5'd0);
        #1;
        chk("t5_stall_b", {31'b0, rd_ready}, 32'h0);
        rd(1'b1, 5'd0, 5'd5, 1'b0, 5'd0);
        tick();
        chk("t5_r0", rd_data_a, 32'h0);
        chk("t5_r5", rd_data_b, 32'hDEAD_BEEF);

        // reset mid-stall with busy r2 and r8
        rd(1'b1, 5'd0, 5'd0, 1'b1, 5'd2);
        tick();
        chk("t1_busy", busy_vec, 32'h0000_0104);
        rd(1'b1, 5'd2, 5'd8, 1'b0, 5'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("t1_busy0", busy_vec, 32'h0);
        chk("t1_vld0", {31'b0, rd_data_vld}, 32'h0);
        chk("t1_db0", rd_data_b, 32'h0);
        tick();
        chk("t1_vld_hold", {31'b0, rd_data_vld}, 32'h0);
        reset = 1'b1;
        rd(1'b1, 5'd5, 5'd8, 1'b0, 5'd0);
        tick();
        rd(1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        chk("t1_r5", rd_data_a, 32'h0);
        chk("t1_r8", rd_data_b, 32'h0);
        chk("t1_vld", {31'b0, rd_data_vld}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
